// File: rtl/full_adder_checker_pkg.sv
// Shared definitions for the full-adder checker.
// This package holds the FSM encoding, the vector-space constants and the
// small index helpers.
package fa_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int         NUM_VEC  = 8;
  localparam logic [7:0] FULL_COV = 8'hFF;

  // Vector index as seen on the coverage mask: {cin,b,a}
  function automatic logic [2:0] vec_idx(input logic a, input logic b, input logic cin);
    return {cin, b, a};
  endfunction

  // One-hot coverage bit for a vector index
  function automatic logic [7:0] vec_bit(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/full_adder_checker_if.sv
// Sample/result bundle between the stimulus side and the full-adder checker.
// The master side drives the sample; the slave side is the checker.
interface full_adder_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             vld;
  logic             a;
  logic             b;
  logic             cin;
  logic             sum;
  logic             cout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       cov_mask;
  logic [2:0]       first_err_vec;
  logic             first_err_vld;
  logic             timeout;
  logic             order_err;

  modport master (
    output start, vld, a, b, cin, sum, cout,
    input  busy, done, pass, err_cnt, cov_mask, first_err_vec,
           first_err_vld, timeout, order_err
  );

  modport slave (
    input  start, vld, a, b, cin, sum, cout,
    output busy, done, pass, err_cnt, cov_mask, first_err_vec,
           first_err_vld, timeout, order_err
  );
endinterface

// File: rtl/full_adder_checker_golden.sv
// Combinational reference full adder that the checker scores samples against.
module fa_golden (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic exp_sum,
  output logic exp_cout
);
  assign exp_sum  = a ^ b ^ cin;
  assign exp_cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder_checker.sv
// Full-adder checker: scores sampled adder responses against fa_golden,
// tracks vector coverage per sweep and aborts on an idle timeout.
// Optional macro FA_CHK_SEQ_EN adds sample-order checking (order_err).
module full_adder_checker
  import fa_chk_pkg::*;
#(
  parameter int ERR_W      = 8,
  parameter int NUM_SWEEPS = 1,
  parameter int TIMEOUT    = 64
) (
  input logic               clk,
  input logic               rst_n,
  full_adder_checker_if.slave bus
);

  localparam int SW_W = $clog2(NUM_SWEEPS + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       cov_q, cov_d;
  logic [SW_W-1:0]  sweep_q, sweep_d;
  logic [TM_W-1:0]  timer_q, timer_d;
  logic [2:0]       fev_q, fev_d;
  logic             fvld_q, fvld_d;
  logic             tmo_q, tmo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
`ifdef FA_CHK_SEQ_EN
  logic             ord_q, ord_d;
  logic [2:0]       exp_idx_q, exp_idx_d;
`endif

  logic       exp_sum_s;
  logic       exp_cout_s;
  logic [2:0] idx_s;
  logic       mism_s;
  logic [7:0] cov_upd_s;

  fa_golden u_golden (
    .a       (bus.a),
    .b       (bus.b),
    .cin     (bus.cin),
    .exp_sum (exp_sum_s),
    .exp_cout(exp_cout_s)
  );

  assign idx_s  = vec_idx(bus.a, bus.b, bus.cin);
  assign mism_s = (bus.sum != exp_sum_s) || (bus.cout != exp_cout_s);

  // Next-state and scoring: run entry clears, RUN scores samples and runs the idle timer
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cov_d     = cov_q;
    sweep_d   = sweep_q;
    timer_d   = timer_q;
    fev_d     = fev_q;
    fvld_d    = fvld_q;
    tmo_d     = tmo_q;
    cov_upd_s = 8'h00;
`ifdef FA_CHK_SEQ_EN
    ord_d     = ord_q;
    exp_idx_d = exp_idx_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          err_d   = '0;
          cov_d   = 8'h00;
          sweep_d = '0;
          timer_d = '0;
          fvld_d  = 1'b0;
          tmo_d   = 1'b0;
`ifdef FA_CHK_SEQ_EN
          ord_d     = 1'b0;
          exp_idx_d = 3'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (bus.vld) begin
          timer_d = '0;
          if (mism_s) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end else begin
              err_d = err_q;
            end
            if (!fvld_q) begin
              fev_d  = idx_s;
              fvld_d = 1'b1;
            end else begin
              fev_d  = fev_q;
              fvld_d = 1'b1;
            end
          end else begin
            err_d = err_q;
          end
`ifdef FA_CHK_SEQ_EN
          if (idx_s != exp_idx_q) begin
            ord_d = 1'b1;
          end else begin
            ord_d = ord_q;
          end
          exp_idx_d = exp_idx_q + 3'd1;
`endif
          cov_upd_s = cov_q | vec_bit(idx_s);
          // A full mask closes the sweep; the mask restarts empty on the same edge
          if (cov_upd_s == FULL_COV) begin
            cov_d   = 8'h00;
            sweep_d = sweep_q + SW_W'(1);
            if (sweep_d == SW_W'(NUM_SWEEPS)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            cov_d   = cov_upd_s;
            sweep_d = sweep_q;
          end
        end else begin
          timer_d = timer_q + TM_W'(1);
          if (timer_d == TM_W'(TIMEOUT)) begin
            state_d = ST_DONE;
            tmo_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            tmo_d   = tmo_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
`ifdef FA_CHK_SEQ_EN
    pass_d = done_d && (err_d == '0) && !tmo_d && !ord_d;
`else
    pass_d = done_d && (err_d == '0) && !tmo_d;
`endif
  end

  // State and result registers; reset discards any run in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      cov_q   <= 8'h00;
      sweep_q <= '0;
      timer_q <= '0;
      fev_q   <= 3'd0;
      fvld_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      sweep_q <= sweep_d;
      timer_q <= timer_d;
      fev_q   <= fev_d;
      fvld_q  <= fvld_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef FA_CHK_SEQ_EN
  // Sample-order tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_q     <= 1'b0;
      exp_idx_q <= 3'd0;
    end else begin
      ord_q     <= ord_d;
      exp_idx_q <= exp_idx_d;
    end
  end
  assign bus.order_err = ord_q;
`else
  assign bus.order_err = 1'b0;
`endif

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.cov_mask      = cov_q;
  assign bus.first_err_vec = fev_q;
  assign bus.first_err_vld = fvld_q;
  assign bus.timeout       = tmo_q;

endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench for full_adder_checker. dut0 uses default parameters;
// dut1 (ERR_W=2, NUM_SWEEPS=2) shares the same stimulus for the saturation case.
module tb_full_adder_checker;
  import fa_chk_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start_s = 1'b0, vld_s = 1'b0, a_s = 1'b0, b_s = 1'b0;
  logic cin_s = 1'b0, sum_s = 1'b0, cout_s = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  // Hand-computed adder truth tables, bit k = response for {cin,b,a}=k
  logic [7:0] sum_tbl  = 8'h96;
  logic [7:0] cout_tbl = 8'hE8;

  logic exp_ord;
  logic exp_pass;

  full_adder_checker_if #(.ERR_W(8)) bus0 ();
  full_adder_checker_if #(.ERR_W(2)) bus1 ();

  assign bus0.start = start_s;
  assign bus0.vld   = vld_s;
  assign bus0.a     = a_s;
  assign bus0.b     = b_s;
  assign bus0.cin   = cin_s;
  assign bus0.sum   = sum_s;
  assign bus0.cout  = cout_s;
  assign bus1.start = start_s;
  assign bus1.vld   = vld_s;
  assign bus1.a     = a_s;
  assign bus1.b     = b_s;
  assign bus1.cin   = cin_s;
  assign bus1.sum   = sum_s;
  assign bus1.cout  = cout_s;

  full_adder_checker #(.ERR_W(8), .NUM_SWEEPS(1), .TIMEOUT(64)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.slave)
  );

  full_adder_checker #(.ERR_W(2), .NUM_SWEEPS(2), .TIMEOUT(64)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_s = 1'b1;
    step();
    start_s = 1'b0;
  endtask

  // Apply vector k for one cycle; optionally flip sum or force cout low
  task automatic send(input int k, input logic flip_sum, input logic cout0);
    logic [2:0] v;
    v      = k[2:0];
    vld_s  = 1'b1;
    a_s    = v[0];
    b_s    = v[1];
    cin_s  = v[2];
    sum_s  = sum_tbl[v] ^ flip_sum;
    cout_s = cout0 ? 1'b0 : cout_tbl[v];
    step();
    vld_s  = 1'b0;
  endtask

  initial begin
`ifdef FA_CHK_SEQ_EN
    exp_ord  = 1'b1;
    exp_pass = 1'b0;
`else
    exp_ord  = 1'b0;
    exp_pass = 1'b1;
`endif
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_busy", 32'(bus0.busy), 32'd0);
    check_val("rst_done", 32'(bus0.done), 32'd0);
    check_val("rst_err",  32'(bus0.err_cnt), 32'd0);
    check_val("rst_cov",  32'(bus0.cov_mask), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // S1: correct adder, ascending vectors
    pulse_start();
    check_val("s1_busy", 32'(bus0.busy), 32'd1);
    for (int k = 0; k < 3; k++) send(k, 1'b0, 1'b0);
    check_val("s1_cov3", 32'(bus0.cov_mask), 32'h07);
    for (int k = 3; k < NUM_VEC - 1; k++) send(k, 1'b0, 1'b0);
    check_val("s1_done7", 32'(bus0.done), 32'd0);
    send(7, 1'b0, 1'b0);
    check_val("s1_done", 32'(bus0.done), 32'd1);
    check_val("s1_busy_end", 32'(bus0.busy), 32'd0);
    check_val("s1_pass", 32'(bus0.pass), 32'd1);
    check_val("s1_err",  32'(bus0.err_cnt), 32'd0);
    check_val("s1_cov_wrap", 32'(bus0.cov_mask), 32'd0);
    check_val("s1_fvld", 32'(bus0.first_err_vld), 32'd0);

    // S2: cout stuck at 0, restarted from DONE
    pulse_start();
    check_val("s2_done_clr", 32'(bus0.done), 32'd0);
    for (int k = 0; k < NUM_VEC; k++) send(k, 1'b0, 1'b1);
    check_val("s2_done", 32'(bus0.done), 32'd1);
    check_val("s2_err",  32'(bus0.err_cnt), 32'd4);
    check_val("s2_fev",  32'(bus0.first_err_vec), 32'd3);
    check_val("s2_fvld", 32'(bus0.first_err_vld), 32'd1);
    check_val("s2_pass", 32'(bus0.pass), 32'd0);

    // S3: idle timeout
    pulse_start();
    for (int i = 0; i < 63; i++) step();
    check_val("s3_done63", 32'(bus0.done), 32'd0);
    check_val("s3_busy63", 32'(bus0.busy), 32'd1);
    step();
    check_val("s3_done", 32'(bus0.done), 32'd1);
    check_val("s3_tmo",  32'(bus0.timeout), 32'd1);
    check_val("s3_pass", 32'(bus0.pass), 32'd0);
    check_val("s3_err",  32'(bus0.err_cnt), 32'd0);

    // S5: dut1 saturates at 3 over two sweeps with 5 faults
    pulse_start();
    for (int k = 0; k < NUM_VEC; k++) send(k, (k < 3) ? 1'b1 : 1'b0, 1'b0);
    for (int k = 0; k < NUM_VEC - 1; k++) send(k, (k < 2) ? 1'b1 : 1'b0, 1'b0);
    check_val("s5_done15", 32'(bus1.done), 32'd0);
    check_val("s5_err15",  32'(bus1.err_cnt), 32'd3);
    send(7, 1'b0, 1'b0);
    check_val("s5_done", 32'(bus1.done), 32'd1);
    check_val("s5_err",  32'(bus1.err_cnt), 32'd3);
    check_val("s5_pass", 32'(bus1.pass), 32'd0);
    check_val("s5_fev",  32'(bus1.first_err_vec), 32'd0);

    // S4: out-of-order vectors 0,1,3,2,4..7
    pulse_start();
    send(0, 1'b0, 1'b0);
    send(1, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0);
    for (int k = 4; k < NUM_VEC; k++) send(k, 1'b0, 1'b0);
    check_val("s4_done", 32'(bus0.done), 32'd1);
    check_val("s4_ord",  32'(bus0.order_err), 32'(exp_ord));
    check_val("s4_pass", 32'(bus0.pass), 32'(exp_pass));
    check_val("s4_err",  32'(bus0.err_cnt), 32'd0);

    // S6: reset mid-run after 4 samples
    pulse_start();
    for (int k = 0; k < 4; k++) send(k, 1'b0, 1'b1);
    check_val("s6_cov_pre", 32'(bus0.cov_mask), 32'h0F);
    check_val("s6_err_pre", 32'(bus0.err_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("s6_busy", 32'(bus0.busy), 32'd0);
    check_val("s6_err",  32'(bus0.err_cnt), 32'd0);
    check_val("s6_cov",  32'(bus0.cov_mask), 32'd0);
    check_val("s6_fvld", 32'(bus0.first_err_vld), 32'd0);
    check_val("s6_fev",  32'(bus0.first_err_vec), 32'd0);
    check_val("s6_done", 32'(bus0.done), 32'd0);
    check_val("s6_pass", 32'(bus0.pass), 32'd0);
    check_val("s6_tmo",  32'(bus0.timeout), 32'd0);
    check_val("s6_ord",  32'(bus0.order_err), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 4; k < 7; k++) send(k, 1'b0, 1'b1);
    check_val("s6_busy_post", 32'(bus0.busy), 32'd0);
    check_val("s6_cov_post",  32'(bus0.cov_mask), 32'd0);
    check_val("s6_err_post",  32'(bus0.err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
